// File: rtl/ball_pkg.sv
// Shared types, playfield defaults and saturating/clamping helpers for the ball mover.
package ball_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VEL    = 3'd1,
        REQ_X  = 3'd2,
        REQ_Y  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam int DEF_X_MAX   = 159;
    localparam int DEF_Y_MAX   = 119;
    localparam int DEF_X_START = 80;
    localparam int DEF_Y_START = 60;

    // Symmetric saturation to [-vmax, +vmax].
    function automatic int sat_vel(input int v, input int vmax);
        int r;
        r = v;
        if (v > vmax) begin
            r = vmax;
        end else if (v < -vmax) begin
            r = -vmax;
        end
        return r;
    endfunction

    function automatic int clamp_pos(input int p, input int pmax);
        int r;
        r = p;
        if (p < 0) begin
            r = 0;
        end else if (p > pmax) begin
            r = pmax;
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Free-running divider that emits a one-cycle physics tick at its terminal count.
module ball_tick_gen #(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 30,
    parameter int CNTR_WIDTH             = 32,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int TERM = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                          : (CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ) - 1;
    localparam logic [CNTR_WIDTH-1:0] TERM_CNT = CNTR_WIDTH'(TERM);

    logic [CNTR_WIDTH-1:0] cnt;

    assign tick = (cnt == TERM_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ball_physics.sv
// Tilt-driven ball mover: integrates acceleration into velocity and position, then
// checks each axis move against the maze map before committing it to x_out/y_out.
module ball_physics
    import ball_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 30,
    parameter int CNTR_WIDTH             = 32,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5,
    parameter int ACCEL_WIDTH            = 8,
    parameter int DEAD_ZONE              = 8,
    parameter int ACCEL_SHIFT            = 2,
    parameter int VEL_WIDTH              = 8,
    parameter int VEL_MAX                = 63,
    parameter int VEL_SHIFT              = 2,
    parameter int POS_WIDTH              = 8,
    parameter int X_MAX                  = DEF_X_MAX,
    parameter int Y_MAX                  = DEF_Y_MAX,
    parameter int X_START                = DEF_X_START,
    parameter int Y_START                = DEF_Y_START
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [ACCEL_WIDTH-1:0] accel_x_in,
    input  logic signed [ACCEL_WIDTH-1:0] accel_y_in,
    output logic                          map_req,
    output logic [POS_WIDTH-1:0]          map_x,
    output logic [POS_WIDTH-1:0]          map_y,
    input  logic                          map_valid,
    input  logic                          map_wall,
    output logic [POS_WIDTH-1:0]          x_out,
    output logic [POS_WIDTH-1:0]          y_out,
    output logic                          update_done,
    output logic                          busy,
    output logic                          overrun
);

    // Map handshake: map_req/map_x/map_y are a pure function of state and stay
    // constant for the whole REQ_X/REQ_Y visit; a query is accepted on the first
    // rising edge where map_req and map_valid are both high, and map_wall is only
    // looked at on that edge.

    state_t state, state_next;
    logic   tick;

    logic signed [ACCEL_WIDTH-1:0] accel_q   [2];
    logic signed [VEL_WIDTH-1:0]   vel_q     [2];
    logic [POS_WIDTH-1:0]          pos_out   [2];
    logic [POS_WIDTH-1:0]          pos_new   [2];
    logic [POS_WIDTH-1:0]          cand_q    [2];
    logic                          move_q    [2];

    logic signed [VEL_WIDTH-1:0]   vel_calc  [2];
    logic [POS_WIDTH-1:0]          cand_calc [2];
    logic                          move_calc [2];

    ball_tick_gen #(
        .CLK_FREQUENCY_HZ      (CLK_FREQUENCY_HZ),
        .UPDATE_FREQUENCY_HZ   (UPDATE_FREQUENCY_HZ),
        .CNTR_WIDTH            (CNTR_WIDTH),
        .SIMULATE              (SIMULATE),
        .SIMULATE_FREQUENCY_CNT(SIMULATE_FREQUENCY_CNT)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign x_out = pos_out[0];
    assign y_out = pos_out[1];

    // Per-axis velocity and candidate position, evaluated from the sampled tilt.
    always_comb begin
        int a_i, mag_i, ae_i, v_i, d_i, p_i, sum_i, c_i, max_i;
        vel_calc  = '{default: '0};
        cand_calc = '{default: '0};
        move_calc = '{default: 1'b0};
        for (int i = 0; i < 2; i++) begin
            max_i = (i == 0) ? X_MAX : Y_MAX;
            a_i   = {{(32-ACCEL_WIDTH){accel_q[i][ACCEL_WIDTH-1]}}, accel_q[i]};
            mag_i = (a_i < 0) ? -a_i : a_i;
            ae_i  = (mag_i <= DEAD_ZONE) ? 0 : (a_i >>> ACCEL_SHIFT);
            v_i   = {{(32-VEL_WIDTH){vel_q[i][VEL_WIDTH-1]}}, vel_q[i]};
            if (ae_i != 0) begin
                v_i = sat_vel(v_i + ae_i, VEL_MAX);
            end else if (v_i > 0) begin
                v_i = v_i - 1;
            end else if (v_i < 0) begin
                v_i = v_i + 1;
            end
            d_i   = v_i >>> VEL_SHIFT;
            p_i   = {{(32-POS_WIDTH){1'b0}}, pos_out[i]};
            sum_i = p_i + d_i;
            c_i   = clamp_pos(sum_i, max_i);
            // Hitting the playfield edge kills the momentum on that axis.
            if (c_i != sum_i) begin
                v_i = 0;
            end
            vel_calc[i]  = v_i[VEL_WIDTH-1:0];
            cand_calc[i] = c_i[POS_WIDTH-1:0];
            move_calc[i] = (d_i != 0) && (c_i != p_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (tick) state_next = VEL;
            VEL:     state_next = REQ_X;
            REQ_X:   if (!move_q[0] || map_valid) state_next = REQ_Y;
            REQ_Y:   if (!move_q[1] || map_valid) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        map_req = 1'b0;
        map_x   = '0;
        map_y   = '0;
        unique case (state)
            REQ_X: begin
                if (move_q[0]) begin
                    map_req = 1'b1;
                    map_x   = cand_q[0];
                    map_y   = pos_new[1];
                end
            end
            REQ_Y: begin
                if (move_q[1]) begin
                    map_req = 1'b1;
                    map_x   = pos_new[0];
                    map_y   = cand_q[1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                accel_q[i] <= '0;
                vel_q[i]   <= '0;
                pos_new[i] <= '0;
                cand_q[i]  <= '0;
                move_q[i]  <= 1'b0;
            end
            pos_out[0]  <= POS_WIDTH'(X_START);
            pos_out[1]  <= POS_WIDTH'(Y_START);
            update_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            update_done <= (state == COMMIT);
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        accel_q[0] <= accel_x_in;
                        accel_q[1] <= accel_y_in;
                    end
                end
                VEL: begin
                    for (int i = 0; i < 2; i++) begin
                        vel_q[i]   <= vel_calc[i];
                        cand_q[i]  <= cand_calc[i];
                        move_q[i]  <= move_calc[i];
                        pos_new[i] <= pos_out[i];
                    end
                end
                REQ_X: begin
                    if (move_q[0] && map_valid) begin
                        if (map_wall) begin
                            vel_q[0] <= '0;
                        end else begin
                            pos_new[0] <= cand_q[0];
                        end
                    end
                end
                REQ_Y: begin
                    if (move_q[1] && map_valid) begin
                        if (map_wall) begin
                            vel_q[1] <= '0;
                        end else begin
                            pos_new[1] <= cand_q[1];
                        end
                    end
                end
                COMMIT: begin
                    pos_out[0] <= pos_new[0];
                    pos_out[1] <= pos_new[1];
                end
                default: ;
            endcase
        end
    end

endmodule
